// File: rtl/jtag_to_regbank.sv
// jtag_to_regbank: a bank of NREGS control registers and NREGS status inputs,
// all reached through one user-IR data register.
// Frame layout (TDI enters the MSB, TDO is the LSB): {wr, addr[AW-1:0], data[WIDTH-1:0]}.
// A write completes in a single DR scan. A read needs two scans: the first
// scan sets the address, and the next Capture-DR returns the data.
// Optional feature: define JTAG_REGBANK_WSTROBE_EN to add control_wr, a
// one-cycle write strobe for each register.
module jtag_to_regbank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW = $clog2(NREGS),
  parameter logic [NREGS*WIDTH-1:0] CONTROL_INIT = '0
) (
  input  logic                     jtag_drck,
  input  logic                     jtag_tlr_n,
  input  logic                     jtag_sel,
  input  logic                     jtag_cdr,
  input  logic                     jtag_sdr,
  input  logic                     jtag_udr,
  input  logic                     jtag_tdi,
  output logic                     jtag_tdo,
  output logic [NREGS*WIDTH-1:0]   control,
  input  logic [NREGS*WIDTH-1:0]   status
`ifdef JTAG_REGBANK_WSTROBE_EN
  ,
  output logic [NREGS-1:0]         control_wr
`endif
);

  localparam int unsigned L = 1 + AW + WIDTH;

  logic [L-1:0]     sr;
  logic [AW-1:0]    rd_addr;
  logic             err;

  logic [WIDTH-1:0] rd_data;
  logic [AW-1:0]    up_addr;
  logic             up_wr;
  logic [NREGS-1:0] wr_sel;
  logic             wr_hit;

  // Read mux and write decode. An address with no matching register reads
  // as zero and selects nothing for a write.
  always_comb begin
    up_addr = sr[L-2 -: AW];
    up_wr   = sr[L-1];
    rd_data = '0;
    wr_sel  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr == AW'(i)) rd_data = status[i*WIDTH +: WIDTH];
      if (up_wr && (up_addr == AW'(i))) wr_sel[i] = 1'b1;
    end
    wr_hit = |wr_sel;
  end

  assign jtag_tdo = sr[0];

  // DR state. Precedence is reset, then capture, then shift, then update.
  // Capture, shift and update act only when this user IR is selected.
  always_ff @(posedge jtag_drck) begin
    if (!jtag_tlr_n) begin
      sr      <= '0;
      rd_addr <= '0;
      err     <= 1'b0;
      control <= CONTROL_INIT;
    end else if (jtag_sel) begin
      if (jtag_cdr) begin
        sr  <= {err, rd_addr, rd_data};
        err <= 1'b0;
      end else if (jtag_sdr) begin
        sr <= {jtag_tdi, sr[L-1:1]};
      end else if (jtag_udr) begin
        rd_addr <= up_addr;
        for (int i = 0; i < NREGS; i++) begin
          if (wr_sel[i]) control[i*WIDTH +: WIDTH] <= sr[WIDTH-1:0];
        end
        if (up_wr && !wr_hit) err <= 1'b1;
      end
    end
  end

`ifdef JTAG_REGBANK_WSTROBE_EN
  // The strobe lines up with the new control value. A dropped write gives
  // no strobe, because wr_sel stays empty.
  always_ff @(posedge jtag_drck) begin
    if (!jtag_tlr_n) begin
      control_wr <= '0;
    end else if (jtag_sel && !jtag_cdr && !jtag_sdr && jtag_udr) begin
      control_wr <= wr_sel;
    end else begin
      control_wr <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_jtag_to_regbank.sv
// Bench for jtag_to_regbank. It drives two instances from shared JTAG pins:
//   - inst 0 has NREGS=4, a power-of-two bank.
//   - inst 1 has NREGS=3, so address 3 is out of range.
// Each instance has its own select line. A register-level model computes
// the expected outputs, and the bench compares them on every negedge.
module tb_jtag_to_regbank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        tlr_n, cdr, sdr, udr, tdi;
  logic [1:0]  sel;
  logic [31:0] st4;
  logic [23:0] st3;
  logic [31:0] ctl4;
  logic [23:0] ctl3;
  logic        tdo4, tdo3;
`ifdef JTAG_REGBANK_WSTROBE_EN
  logic [3:0]  wr4;
  logic [2:0]  wr3;
`endif

  jtag_to_regbank #(.WIDTH(8), .NREGS(4), .CONTROL_INIT(32'h04030201)) u_d4 (
    .jtag_drck(clk), .jtag_tlr_n(tlr_n), .jtag_sel(sel[0]),
    .jtag_cdr(cdr), .jtag_sdr(sdr), .jtag_udr(udr), .jtag_tdi(tdi),
    .jtag_tdo(tdo4), .control(ctl4), .status(st4)
`ifdef JTAG_REGBANK_WSTROBE_EN
    , .control_wr(wr4)
`endif
  );

  jtag_to_regbank #(.WIDTH(8), .NREGS(3), .CONTROL_INIT(24'h030201)) u_d3 (
    .jtag_drck(clk), .jtag_tlr_n(tlr_n), .jtag_sel(sel[1]),
    .jtag_cdr(cdr), .jtag_sdr(sdr), .jtag_udr(udr), .jtag_tdi(tdi),
    .jtag_tdo(tdo3), .control(ctl3), .status(st3)
`ifdef JTAG_REGBANK_WSTROBE_EN
    , .control_wr(wr3)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: register arrays, the DR value, the read pointer, the error flag.
  int unsigned nregs [2] = '{4, 3};
  logic [7:0]  m_ctrl [2][4];
  logic [10:0] m_sr   [2];
  logic [1:0]  m_rd   [2];
  logic        m_err  [2];
  logic [3:0]  m_wr   [2];

  function automatic logic [7:0] stat_byte(input int i, input logic [1:0] a);
    logic [31:0] s;
    s = (i == 0) ? st4 : {8'h00, st3};
    return s[int'(a)*8 +: 8];
  endfunction

  // Apply the rules for one DR-clock edge, using the inputs sampled at that edge.
  task automatic model_edge();
    logic [1:0] a;
    for (int i = 0; i < 2; i++) begin
      m_wr[i] = 4'b0000;
      if (!tlr_n) begin
        for (int r = 0; r < 4; r++) m_ctrl[i][r] = 8'(r + 1);
        m_sr[i] = '0; m_rd[i] = '0; m_err[i] = 1'b0;
      end else if (sel[i]) begin
        if (cdr) begin
          m_sr[i]  = {m_err[i], m_rd[i], (int'(m_rd[i]) < nregs[i]) ? stat_byte(i, m_rd[i]) : 8'h00};
          m_err[i] = 1'b0;
        end else if (sdr) begin
          m_sr[i] = {tdi, m_sr[i][10:1]};
        end else if (udr) begin
          a = m_sr[i][9:8];
          m_rd[i] = a;
          if (m_sr[i][10]) begin
            if (int'(a) < nregs[i]) begin
              m_ctrl[i][a] = m_sr[i][7:0];
              m_wr[i][a]   = 1'b1;
            end else begin
              m_err[i] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    if (checking) begin
      check("ctl4", ctl4, {m_ctrl[0][3], m_ctrl[0][2], m_ctrl[0][1], m_ctrl[0][0]});
      check("ctl3", {8'h00, ctl3}, {8'h00, m_ctrl[1][2], m_ctrl[1][1], m_ctrl[1][0]});
      check("tdo4", {31'd0, tdo4}, {31'd0, m_sr[0][0]});
      check("tdo3", {31'd0, tdo3}, {31'd0, m_sr[1][0]});
`ifdef JTAG_REGBANK_WSTROBE_EN
      check("wr4", {28'd0, wr4}, {28'd0, m_wr[0]});
      check("wr3", {29'd0, wr3}, {29'd0, m_wr[1][2:0]});
`endif
    end
  end

  // Drive one DR-clock cycle, then advance the model past that edge.
  task automatic cyc(input logic c, input logic s, input logic u, input logic t);
    cdr = c; sdr = s; udr = u; tdi = t;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // One DR scan: capture, 11 shifts, update. cap collects the TDO bits of
  // the selected instance, LSB first.
  task automatic scan(input logic [10:0] frame, output logic [10:0] cap);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) begin
      cap[k] = sel[1] ? tdo3 : tdo4;
      cyc(1'b0, 1'b1, 1'b0, frame[k]);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  logic [10:0] cap;

  initial begin
    tlr_n = 1'b0; sel = 2'b11; cdr = 1'b0; sdr = 1'b0; udr = 1'b0; tdi = 1'b0;
    st4 = 32'hDEADBEEF; st3 = 24'h112233;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tlr_n = 1'b1;
    checking = 1'b1;
    // Reset values
    check("rst_ctl4", ctl4, 32'h04030201);
    check("rst_ctl3", {8'h00, ctl3}, 32'h00030201);
    check("rst_tdo", {31'd0, tdo4}, 32'd0);
`ifdef JTAG_REGBANK_WSTROBE_EN
    check("rst_wr", {28'd0, wr4}, 32'd0);
`endif

    // Write 0xA5 to register 2
    sel = 2'b01;
    scan({1'b1, 2'd2, 8'hA5}, cap);
    check("wr_ctl4", ctl4, 32'h04A50201);
`ifdef JTAG_REGBANK_WSTROBE_EN
    check("wr_strobe", {28'd0, wr4}, 32'h4);
`endif
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef JTAG_REGBANK_WSTROBE_EN
    check("wr_strobe_end", {28'd0, wr4}, 32'h0);
`endif

    // Two-scan read of status register 3
    scan({1'b0, 2'd3, 8'h00}, cap);
    scan({1'b0, 2'd3, 8'h00}, cap);
    check("rd_word", {21'd0, cap}, 32'h3DE);
    scan({1'b0, 2'd0, 8'h00}, cap);
    check("rd_word2", {21'd0, cap}, 32'h3DE);
    scan({1'b0, 2'd0, 8'h00}, cap);
    check("rd_word3", {21'd0, cap}, 32'h0EF);

    // Deselected: 11 shifts and an update must have no effect
    sel = 2'b00;
    for (int k = 0; k < 11; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("desel_ctl4", ctl4, 32'h04A50201);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // NREGS=3: a valid write, then a write to address 3 that is out of range
    sel = 2'b10;
    scan({1'b1, 2'd1, 8'h3C}, cap);
    check("d3_wr", {8'h00, ctl3}, 32'h00033C01);
    scan({1'b1, 2'd3, 8'h55}, cap);
    check("oor_ctl3", {8'h00, ctl3}, 32'h00033C01);
`ifdef JTAG_REGBANK_WSTROBE_EN
    check("oor_strobe", {29'd0, wr3}, 32'h0);
`endif
    scan({1'b0, 2'd3, 8'h00}, cap);
    check("oor_err", {21'd0, cap}, 32'h700);
    scan({1'b0, 2'd1, 8'h00}, cap);
    check("oor_clr", {21'd0, cap}, 32'h300);
    scan({1'b0, 2'd1, 8'h00}, cap);
    check("d3_rd1", {21'd0, cap}, 32'h122);

    // Reset in the middle of a scan drops the partial frame
    sel = 2'b01;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    tlr_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tlr_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("midrst_ctl4", ctl4, 32'h04030201);
    check("midrst_ctl3", {8'h00, ctl3}, 32'h00030201);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
